serial_word_assembler: RTL and testbench
========================================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 8, meaning serial word width in bits (legal range 2..32).
REQ-002 The block SHALL have port Clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port Reset  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port Enable  input  1  qualifies every shift/start action; low = hold.
REQ-005 The block SHALL have port Start  input  1  word-alignment strobe, asserted on the same edge the transmitter loads its word.
REQ-006 The block SHALL have port Serial_In  input  1  serial data, LSB first.
REQ-007 The block SHALL have port Word_Ack  input  1  consumer acknowledge of Parallel_Out.
REQ-008 The block SHALL have port Parallel_Out  output  WORD_LENGTH  last completed word.
REQ-009 The block SHALL have port Word_Valid  output  1  Parallel_Out holds an unacknowledged word.
REQ-010 The block SHALL have port Busy  output  1  high while in SHIFT state.
REQ-011 The block SHALL have port Overrun  output  1  sticky: a completed word replaced an unacknowledged one.

Function
REQ-012 The FSM SHALL have two states: IDLE and SHIFT.
REQ-013 IDLE: on an edge with Enable=1 and Start=1 -> SHIFT, bit counter cleared to 0, shift register cleared to 0; no Serial_In sample on that edge.
REQ-014 SHIFT: each edge with Enable=1 and Start=0 -> shift register takes {Serial_In, shift_reg[WORD_LENGTH-1:1]}, bit counter +1.
REQ-015 When the sample that makes the counter equal WORD_LENGTH is taken, on that same edge: Parallel_Out <= assembled word, Word_Valid <= 1, FSM -> IDLE, counter -> 0.
REQ-016 Latency: Word_Valid SHALL rise exactly WORD_LENGTH enabled edges after the edge that accepted Start.
REQ-017 Start=1 with Enable=1 while in SHIFT SHALL restart: partial word discarded, counter and shift register cleared to 0, remain in SHIFT; no sample taken on that edge.
REQ-018 Enable=0 SHALL freeze FSM, counter, and shift register; Start and Serial_In are ignored.
REQ-019 Word_Ack SHALL be honoured regardless of Enable: Word_Valid=1 and Word_Ack=1 -> Word_Valid <= 0 next edge; Parallel_Out retains its value.
REQ-020 Word_Ack while Word_Valid=0 SHALL have no effect.
REQ-021 Completion on the same edge as Word_Ack with Word_Valid=1: new word loaded, Word_Valid stays 1, Overrun unchanged.
REQ-022 Completion while Word_Valid=1 and Word_Ack=0: new word overwrites Parallel_Out, Word_Valid stays 1, Overrun <= 1.
REQ-023 Overrun SHALL clear only by Reset.
REQ-024 Busy SHALL equal (state == SHIFT), registered, glitch-free.
REQ-025 Bit counter width SHALL be clog2(WORD_LENGTH+1); the counter never exceeds WORD_LENGTH.

Reset
REQ-026 Reset=0 SHALL asynchronously force: state IDLE, counter 0, shift register 0, Parallel_Out 0, Word_Valid 0, Busy 0, Overrun 0.
REQ-027 Reset asserted mid-word SHALL discard the partial word; after release the block waits in IDLE for a new Start.
REQ-028 Reset release SHALL take effect on the first rising Clk edge after deassertion; no action on that edge other than normal IDLE evaluation.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (IDLE=1'b0, SHIFT=1'b1) and the clog2 width function.
REQ-030 The bit counter SHALL be a sub-module named bit_counter (inputs Clk, Reset, Enable, Clear; output count; parameter WIDTH).
REQ-031 All registers SHALL use nonblocking assignment in a single clocked process per register group; no latches.

Verification
REQ-032 WORD_LENGTH=8, Enable=1, Start pulse then serial bits 1,0,1,0,0,1,0,1 (LSB first) -> Word_Valid rises 8 edges after Start, Parallel_Out=8'hA5, Busy low same edge.
REQ-033 Back-to-back to the PISO transmitter: load 8'h3C with Start tied to Shift_Load -> Parallel_Out=8'h3C; repeat 8'hFF, 8'h00 with Word_Ack each -> Overrun stays 0.
REQ-034 Enable toggled 0 every other cycle during word 8'h96 -> same result, Word_Valid after 8 enabled edges (16 clocks).
REQ-035 Word 8'h11 completes, no Ack, then word 8'h22 completes -> Parallel_Out=8'h22, Word_Valid=1, Overrun=1; Ack on completion edge instead -> Overrun=0.
REQ-036 Start re-asserted after 5 bits, then full word 8'h5A -> Parallel_Out=8'h5A, only one Word_Valid rise.
REQ-037 Reset pulsed low after 3 bits -> all outputs 0 immediately; next Start + 8'hC3 -> Parallel_Out=8'hC3.

Source files
------------

// File: rtl/serial_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_assembler_pkg
//  Description : Shared definitions for the serial word assembler: FSM state
//                encoding and the counter width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_word_assembler_pkg;

    // Explicit 1-bit state encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Smallest r such that 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : serial_word_assembler_pkg
`default_nettype wire

// File: rtl/serial_word_assembler_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Up-counter with synchronous clear (priority over count
//                enable) and asynchronous active-low reset.
//  Ports       : Clk    - rising-edge clock
//                Reset  - asynchronous reset, active-low
//                Enable - increment on this edge
//                Clear  - force to zero on this edge (wins over Enable)
//                count  - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else if (Clear) begin
            count_q <= '0;
        end else if (Enable) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule : bit_counter
`default_nettype wire

// File: rtl/serial_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_assembler
//  Description : Serial-in / parallel-out word assembler (LSB first) with a
//                Start alignment strobe, a valid/acknowledge handshake on
//                the completed word and a sticky overrun flag.
//  Ports       : Clk          - rising-edge clock
//                Reset        - asynchronous reset, active-low
//                Enable       - qualifies every shift/start action
//                Start        - word-alignment strobe
//                Serial_In    - serial data, LSB first
//                Word_Ack     - consumer acknowledge of Parallel_Out
//                Parallel_Out - last completed word
//                Word_Valid   - Parallel_Out holds an unacknowledged word
//                Busy         - high while assembling a word
//                Overrun      - sticky: a word replaced an unacknowledged one
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic                   Start,
    input  logic                   Serial_In,
    input  logic                   Word_Ack,
    output logic [WORD_LENGTH-1:0] Parallel_Out,
    output logic                   Word_Valid,
    output logic                   Busy,
    output logic                   Overrun
);

    localparam int                 c_CNT_W = clog2(WORD_LENGTH + 1);
    // Count value before the final sample of a word is taken.
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WORD_LENGTH - 1);

    state_e                   state_q;
    logic                     busy_q;
    logic [c_CNT_W-1:0]       count;

    // Only the upper WORD_LENGTH-1 bits of the shift register are kept: the
    // lowest bit is shifted out on the next sample and never observed.
    logic [WORD_LENGTH-2:0]   shift_q, shift_d;
    logic [WORD_LENGTH-1:0]   par_q, par_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    logic                     w_start;
    logic                     w_sample;
    logic                     w_done;
    logic [WORD_LENGTH-1:0]   w_shifted;

    // Start (in either state) aligns; samples are taken only in SHIFT.
    assign w_start   = Enable & Start;
    assign w_sample  = Enable & ~Start & (state_q == SHIFT);
    assign w_done    = w_sample & (count == c_LAST);
    assign w_shifted = {Serial_In, shift_q};

    bit_counter #(
        .WIDTH (c_CNT_W)
    ) u_bit_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (w_sample),
        .Clear  (w_start | w_done),
        .count  (count)
    );

    // Control FSM; Busy is registered alongside the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else if (w_start) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
        end else if (w_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end
    end

    always_comb begin
        shift_d = shift_q;
        par_d   = par_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (w_start || w_done) begin
            shift_d = '0;
        end else if (w_sample) begin
            shift_d = w_shifted[WORD_LENGTH-1:1];
        end

        if (w_done) begin
            par_d   = w_shifted;
            valid_d = 1'b1;
            // An acknowledge on the completion edge consumes the old word.
            if (valid_q && !Word_Ack) begin
                ovr_d = 1'b1;
            end
        end else if (Word_Ack) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shift_q <= '0;
            par_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Parallel_Out = par_q;
    assign Word_Valid   = valid_q;
    assign Busy         = busy_q;
    assign Overrun      = ovr_q;

endmodule : serial_word_assembler
`default_nettype wire

// File: tb/tb_serial_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_assembler
//  Description : Self-checking bench for serial_word_assembler (8-bit words).
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_assembler;

    localparam int c_WL = 8;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Enable;
    logic            Start;
    logic            Serial_In;
    logic            Word_Ack;
    logic [c_WL-1:0] Parallel_Out;
    logic            Word_Valid;
    logic            Busy;
    logic            Overrun;

    int total = 0;
    int bad   = 0;

    // Bench-side expectation of Word_Valid before each word starts.
    logic m_valid;

    typedef struct {
        logic [7:0] data;      // word sent LSB first
        bit         gap;       // insert a disabled cycle before every bit
        bit         ack_done;  // Word_Ack on the completion edge
        bit         ack_after; // acknowledge after completion
        logic [7:0] exp_po;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [8];

    serial_word_assembler #(
        .WORD_LENGTH (c_WL)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Enable       (Enable),
        .Start        (Start),
        .Serial_In    (Serial_In),
        .Word_Ack     (Word_Ack),
        .Parallel_Out (Parallel_Out),
        .Word_Valid   (Word_Valid),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input bit gap, input bit ack_done,
                             input logic valid_pre, input string tag);
        Enable = 1'b1; Start = 1'b1; Word_Ack = 1'b0; Serial_In = 1'b0;
        tick();
        chk({tag, " busy after start"}, 32'(Busy), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                // Disabled cycle: Start and Serial_In must be ignored.
                Enable = 1'b0; Start = 1'b1; Serial_In = ~d[i];
                tick();
            end
            Enable = 1'b1; Start = 1'b0; Serial_In = d[i];
            Word_Ack = (i == 7) ? ack_done : 1'b0;
            if (i == 7) begin
                chk({tag, " busy before last bit"}, 32'(Busy), 32'd1);
                chk({tag, " valid before last bit"}, 32'(Word_Valid), 32'(valid_pre));
            end
            tick();
        end
        Enable = 1'b0; Start = 1'b0; Word_Ack = 1'b0;
    endtask

    initial begin
        //          data   gap ackd acka exp_po ov
        vecs[0] = '{8'hA5, 0,  0,   1,   8'hA5, 0};
        vecs[1] = '{8'h3C, 0,  0,   1,   8'h3C, 0};
        vecs[2] = '{8'hFF, 0,  0,   1,   8'hFF, 0};
        vecs[3] = '{8'h00, 0,  0,   1,   8'h00, 0};
        vecs[4] = '{8'h96, 1,  0,   1,   8'h96, 0};
        vecs[5] = '{8'h11, 0,  0,   0,   8'h11, 0};
        vecs[6] = '{8'h22, 0,  1,   0,   8'h22, 0};
        vecs[7] = '{8'h44, 0,  0,   1,   8'h44, 1};

        Reset = 1'b0; Enable = 1'b0; Start = 1'b0; Serial_In = 1'b0; Word_Ack = 1'b0;
        tick();
        tick();
        chk("reset po",    32'(Parallel_Out), 32'h0);
        chk("reset valid", 32'(Word_Valid),   32'h0);
        chk("reset busy",  32'(Busy),         32'h0);
        chk("reset ovr",   32'(Overrun),      32'h0);
        Reset = 1'b1;
        tick();
        chk("idle after release busy", 32'(Busy), 32'h0);
        m_valid = 1'b0;

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            send_word(vecs[v].data, vecs[v].gap, vecs[v].ack_done, m_valid, tag);
            chk({tag, " po"},    32'(Parallel_Out), 32'(vecs[v].exp_po));
            chk({tag, " valid"}, 32'(Word_Valid),   32'd1);
            chk({tag, " busy"},  32'(Busy),         32'd0);
            chk({tag, " ovr"},   32'(Overrun),      32'(vecs[v].exp_ov));
            m_valid = 1'b1;
            if (vecs[v].ack_after) begin
                Word_Ack = 1'b1;
                tick();
                chk({tag, " valid after ack"}, 32'(Word_Valid),   32'd0);
                chk({tag, " po after ack"},    32'(Parallel_Out), 32'(vecs[v].exp_po));
                tick();  // ack with nothing valid
                chk({tag, " valid idle ack"}, 32'(Word_Valid), 32'd0);
                chk({tag, " ovr after ack"},  32'(Overrun),    32'(vecs[v].exp_ov));
                Word_Ack = 1'b0;
                m_valid = 1'b0;
            end
        end

        // Restart after 5 bits: partial word dropped, one completion only.
        Enable = 1'b1; Start = 1'b1; Serial_In = 1'b0;
        tick();
        Start = 1'b0; Serial_In = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("restart valid after partial", 32'(Word_Valid), 32'd0);
        send_word(8'h5A, 0, 0, 1'b0, "restart");
        chk("restart po",    32'(Parallel_Out), 32'h5A);
        chk("restart valid", 32'(Word_Valid),   32'd1);
        chk("restart ovr",   32'(Overrun),      32'd1);

        // Asynchronous reset in the middle of a word.
        Enable = 1'b1; Start = 1'b1; Serial_In = 1'b0;
        tick();
        Start = 1'b0; Serial_In = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2 Reset = 1'b0;
        #1;
        chk("async rst po",    32'(Parallel_Out), 32'h0);
        chk("async rst valid", 32'(Word_Valid),   32'h0);
        chk("async rst busy",  32'(Busy),         32'h0);
        chk("async rst ovr",   32'(Overrun),      32'h0);
        tick();
        Reset = 1'b1; Enable = 1'b1; Start = 1'b0; Serial_In = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("post rst waits idle", 32'(Busy),       32'd0);
        chk("post rst no valid",   32'(Word_Valid), 32'd0);
        send_word(8'hC3, 0, 0, 1'b0, "post rst");
        chk("post rst po",    32'(Parallel_Out), 32'hC3);
        chk("post rst valid", 32'(Word_Valid),   32'd1);
        chk("post rst ovr",   32'(Overrun),      32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_word_assembler
`default_nettype wire
